// File: rtl/pip_sched.sv
// Point-in-polygon query scheduler: buffers POINTS vertices, arbitrates two requesters
// round-robin, streams the polygon to an external engine and returns its result.
// Optional WAIT timeout is built when PIP_SCHED_TIMEOUT_EN is defined.
module pip_sched #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned POINTS  = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_x,
  input  logic [WIDTH-1:0] load_y,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             poly_valid,
  output logic             busy,
  output logic             pip_enable,
  output logic [WIDTH-1:0] pip_x_check,
  output logic [WIDTH-1:0] pip_y_check,
  output logic [WIDTH-1:0] pip_x_in,
  output logic [WIDTH-1:0] pip_y_in,
  input  logic             pip_finished,
  input  logic [WIDTH-1:0] pip_result
);

  localparam int unsigned   PW   = $clog2(POINTS);
  localparam logic [PW-1:0] LAST = PW'(POINTS - 1);

  if (POINTS < 3 || TIMEOUT < 1) begin : g_param_check
    $error("pip_sched: POINTS must be >= 3 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] vx_q [POINTS];
  logic [WIDTH-1:0] vy_q [POINTS];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, k_q, k_d;
  logic             poly_valid_q, poly_valid_d, prio_q, prio_d, id_q, id_d;
  logic [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d, res_q, res_d;
  logic             load_we, grant0, grant1;
`ifdef PIP_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Loads take precedence over query grants; both only happen in IDLE.
  always_comb begin
    load_we = load_valid && (state_q == IDLE);
    grant0  = (state_q == IDLE) && poly_valid_q && !load_valid && req0_valid &&
              (!req1_valid || !prio_q);
    grant1  = (state_q == IDLE) && poly_valid_q && !load_valid && req1_valid &&
              (!req0_valid || prio_q);
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    poly_valid_d = poly_valid_q;
    prio_d       = prio_q;
    id_d         = id_q;
    k_d          = k_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    res_d        = res_q;
`ifdef PIP_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    if (load_we) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
      if (wr_ptr_q == LAST)    poly_valid_d = 1'b1;
      else if (wr_ptr_q == '0) poly_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d = STREAM;
          k_d     = '0;
          id_d    = grant1;
          prio_d  = grant0;
          qx_d    = grant1 ? req1_x : req0_x;
          qy_d    = grant1 ? req1_y : req0_y;
          res_d   = '0;
`ifdef PIP_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      STREAM: begin
        if (k_q == LAST) begin
          state_d = WAIT;
`ifdef PIP_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      WAIT: begin
        if (pip_finished) begin
          res_d   = pip_result;
          state_d = RESP;
        end
`ifdef PIP_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      poly_valid_q <= 1'b0;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      k_q          <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      res_q        <= '0;
`ifdef PIP_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      poly_valid_q <= poly_valid_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      k_q          <= k_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      res_q        <= res_d;
`ifdef PIP_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      vx_q[wr_ptr_q] <= load_x;
      vy_q[wr_ptr_q] <= load_y;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign poly_valid  = poly_valid_q;
  assign busy        = (state_q != IDLE);
  assign pip_enable  = (state_q == STREAM);
  assign pip_x_in    = pip_enable ? vx_q[k_q] : '0;
  assign pip_y_in    = pip_enable ? vy_q[k_q] : '0;
  assign pip_x_check = busy ? qx_q : '0;
  assign pip_y_check = busy ? qy_q : '0;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = rsp_valid & id_q;
  assign rsp_result  = rsp_valid ? res_q : '0;
`ifdef PIP_SCHED_TIMEOUT_EN
  assign rsp_err     = rsp_valid & err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/pip_sched.md
PIP_SCHED -- requirements
Module: pip_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, coordinate and result width.
REQ-002 SHALL have parameter POINTS, default 5, polygon vertex count (>=3).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles (used only with PIP_SCHED_TIMEOUT_EN).
REQ-004 SHALL have ports:
- clk  input  1  single clock, rising edge.
- rstN  input  1  asynchronous, active-low reset.
- load_valid  input  1  vertex write strobe.
- load_x, load_y  input  WIDTH  vertex coordinates.
- req0_valid, req1_valid  input  1  query requests.
- req0_x, req0_y, req1_x, req1_y  input  WIDTH  query points.
- req0_ready, req1_ready  output  1  query accepted this cycle when ready & valid.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_id  output  1  requester index of the response.
- rsp_result  output  WIDTH  captured engine result.
- rsp_err  output  1  timeout flag.
- poly_valid  output  1  all POINTS vertices loaded.
- busy  output  1  FSM not in IDLE.
- pip_enable  output  1  engine Enable.
- pip_x_check, pip_y_check  output  WIDTH  engine query point.
- pip_x_in, pip_y_in  output  WIDTH  engine vertex stream.
- pip_finished  input  1  engine done.
- pip_result  input  WIDTH  engine Result.

Function
REQ-005 SHALL hold POINTS vertices in an internal buffer written only in IDLE; each accepted load_valid writes at wr_ptr, wr_ptr increments and wraps POINTS-1 -> 0.
REQ-006 SHALL set poly_valid on the write that makes wr_ptr wrap; a write at index 0 while poly_valid is set SHALL clear poly_valid (reload).
REQ-007 SHALL implement FSM IDLE -> STREAM -> WAIT -> RESP -> IDLE.
REQ-008 IDLE: reqN_ready SHALL be high only for the granted requester, only if poly_valid=1 and load_valid=0 (load wins simultaneous events).
REQ-009 Arbitration SHALL be round-robin: priority pointer starts at requester 0, moves to the other requester after every grant; lone requester always wins.
REQ-010 On grant in cycle T, SHALL latch query point and id, drive pip_x_check/pip_y_check from T+1 until return to IDLE.
REQ-011 STREAM SHALL last exactly POINTS cycles (T+1..T+POINTS), pip_enable=1, pip_x_in/pip_y_in = vertex[k] in cycle T+1+k; outside STREAM pip_enable=0, pip_x_in/pip_y_in=0.
REQ-012 WAIT SHALL sample pip_finished each cycle; first high sample at cycle F SHALL capture pip_result and assert rsp_valid at F+1 (RESP).
REQ-013 pip_finished during STREAM SHALL be ignored.
REQ-014 RESP SHALL hold rsp_valid, rsp_id, rsp_result, rsp_err stable until rsp_ready=1; the handshake cycle SHALL return to IDLE, rsp_valid low the next cycle.
REQ-015 Minimum accept-to-accept spacing SHALL be POINTS+3 cycles (engine finished in first WAIT cycle, rsp_ready held high).

Reset
REQ-016 rstN low SHALL asynchronously force IDLE, wr_ptr=0, priority=0, poly_valid=0, busy=0, all ready/valid/pip_* outputs 0, rsp_id/rsp_result/rsp_err 0; vertex buffer contents need not reset.
REQ-017 Reset mid-STREAM/WAIT/RESP SHALL abort the query with no response after release; polygon must be reloaded.

Configuration
REQ-018 With PIP_SCHED_TIMEOUT_EN defined, a WAIT counter SHALL reset on WAIT entry; reaching TIMEOUT cycles without pip_finished SHALL enter RESP with rsp_err=1, rsp_result=0.
REQ-019 Without PIP_SCHED_TIMEOUT_EN, WAIT SHALL persist indefinitely, no counter SHALL exist, rsp_err SHALL be constant 0.

Verification
REQ-020 Load (2,6),(3,3),(3,2),(6,3),(6,5); req0 (4,4); engine model finishes 2 cycles after STREAM with result 1 -> 5 enable cycles in vertex order, rsp_id=0, rsp_result=1.
REQ-021 Requests before 5th vertex load -> req0_ready/req1_ready stay 0; after 5th load, poly_valid=1 next cycle.
REQ-022 req1 alone, then req0 and req1 both valid -> order 1, 0, 1 across three queries.
REQ-023 rsp_ready low 3 cycles in RESP -> rsp fields stable, no new grant, IDLE only after handshake.
REQ-024 PIP_SCHED_TIMEOUT_EN, TIMEOUT=64, engine never finishes -> rsp_valid at WAIT entry+64, rsp_err=1, rsp_result=0.
REQ-025 rstN low during STREAM cycle 3 -> all outputs 0 immediately, poly_valid=0, no response after release.
